// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX->MEM stage handshake and payload bundle
interface ex_mem_stage_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned AOP_W   = 8,
   parameter int unsigned RADDR_W = 5
);
   logic               flush_i;
   logic               valid_EX_i;
   logic               ready_EX_o;
   logic [AOP_W-1:0]   aluop_EX_i;
   logic               wreg_EX_i;
   logic [RADDR_W-1:0] waddr_EX_i;
   logic [DATA_W-1:0]  alurslt_EX_i;
   logic [DATA_W-1:0]  storedata_EX_i;
   logic               valid_MEM_o;
   logic               ready_MEM_i;
   logic [AOP_W-1:0]   aluop_MEM_o;
   logic               wreg_MEM_o;
   logic [RADDR_W-1:0] waddr_MEM_o;
   logic [DATA_W-1:0]  alurslt_MEM_o;
   logic [DATA_W-1:0]  storedata_MEM_o;
   logic [1:0]         count_o;

   // Pipeline control side: drives EX beats, flush and MEM ready
   modport master (
      output flush_i, valid_EX_i, aluop_EX_i, wreg_EX_i, waddr_EX_i,
             alurslt_EX_i, storedata_EX_i, ready_MEM_i,
      input  ready_EX_o, valid_MEM_o, aluop_MEM_o, wreg_MEM_o, waddr_MEM_o,
             alurslt_MEM_o, storedata_MEM_o, count_o
   );

   // Stage side
   modport slave (
      input  flush_i, valid_EX_i, aluop_EX_i, wreg_EX_i, waddr_EX_i,
             alurslt_EX_i, storedata_EX_i, ready_MEM_i,
      output ready_EX_o, valid_MEM_o, aluop_MEM_o, wreg_MEM_o, waddr_MEM_o,
             alurslt_MEM_o, storedata_MEM_o, count_o
   );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM pipeline register with handshake, flush and optional skid entry
module ex_mem_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned AOP_W   = 8,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned NOP_OP  = 0,
   parameter int unsigned SKID    = 1
) (
   input logic           dclk,
   input logic           rst,
   ex_mem_stage_if.slave bus
);
   localparam int unsigned ENT_W = AOP_W + 1 + RADDR_W + 2 * DATA_W;

   // Encoding equals the number of held entries so count_o comes straight from the state flops
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state;
   logic             m_valid;
   logic [ENT_W-1:0] m_q;
   logic [ENT_W-1:0] s_q;
   logic [ENT_W-1:0] in_ent;
   logic [ENT_W-1:0] bubble;
   logic             ready;
   logic             in_xfer;
   logic             out_xfer;

   assign in_ent = {bus.aluop_EX_i, bus.wreg_EX_i, bus.waddr_EX_i,
                    bus.alurslt_EX_i, bus.storedata_EX_i};
   assign bubble = {AOP_W'(NOP_OP), {(ENT_W - AOP_W){1'b0}}};

   // Skid mode: ready depends only on whether S is occupied, so it is a flop output.
   // Single-register mode: MEM ready passes straight through to keep full throughput.
   assign ready    = (SKID != 0) ? (state != ST_FULL) : (!m_valid | bus.ready_MEM_i);
   assign in_xfer  = bus.valid_EX_i & ready;
   assign out_xfer = m_valid & bus.ready_MEM_i;

   // Entry bookkeeping; bubbles are written into M so outputs need no muxing
   always_ff @(posedge dclk) begin
      if (rst || bus.flush_i) begin
         state   <= ST_EMPTY;
         m_valid <= 1'b0;
         m_q     <= bubble;
         s_q     <= '0;
      end else if (SKID != 0) begin
         case (state)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state   <= ST_ONE;
                  m_valid <= 1'b1;
                  m_q     <= in_ent;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  m_q <= in_ent;
               end else if (in_xfer) begin
                  s_q   <= in_ent;
                  state <= ST_FULL;
               end else if (out_xfer) begin
                  m_q     <= bubble;
                  m_valid <= 1'b0;
                  state   <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               // S always drains into M; it never bypasses the head
               if (out_xfer) begin
                  m_q   <= s_q;
                  s_q   <= '0;
                  state <= ST_ONE;
               end
            end
            default: begin
               state   <= ST_EMPTY;
               m_valid <= 1'b0;
               m_q     <= bubble;
               s_q     <= '0;
            end
         endcase
      end else begin
         if (in_xfer) begin
            m_q     <= in_ent;
            m_valid <= 1'b1;
            state   <= ST_ONE;
         end else if (out_xfer) begin
            m_q     <= bubble;
            m_valid <= 1'b0;
            state   <= ST_EMPTY;
         end
      end
   end

   assign bus.ready_EX_o  = ready;
   assign bus.valid_MEM_o = m_valid;
   assign bus.count_o     = state;
   assign {bus.aluop_MEM_o, bus.wreg_MEM_o, bus.waddr_MEM_o,
           bus.alurslt_MEM_o, bus.storedata_MEM_o} = m_q;
endmodule
